// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write-side valid/ready port of the FIFO-backed UART transmitter
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with write FIFO, runtime baud/frame config, gap-free frames
// Optional break generation (send_break port) is built when UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_W      = 16,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_len,
    input  logic             parity_en,
    input  logic [1:0]       parity_mode,
    input  logic             stop_bit_size,
`ifdef UART_TX_BREAK_EN
    input  logic             send_break,
`endif
    uart_tx_fifo_if.slave    wr,
    output logic [LW-1:0]    fifo_level,
    output logic             busy,
    output logic             tx
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK, S_GUARD
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic              push, pop, fifo_empty, fifo_full;

    logic [DATA_W-1:0] word_q;
    logic [1:0]        len_q;
    logic              par_en_q, par_q, stop2_q;
    logic [DIV_W-1:0]  div_q, cnt;
    logic [2:0]        bit_idx, last_idx;
    logic              tick, start_ok, break_req, busy_q, tx_nx;

    logic [DATA_W-1:0] head;
    logic [3:0]        n_bits;
    logic              head_xor, par_bit_nx;

`ifdef UART_TX_BREAK_EN
    assign break_req = send_break;
`else
    assign break_req = 1'b0;
`endif

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == LW'(FIFO_DEPTH));
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    assign wr.wr_ready = !fifo_full || pop;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign fifo_level  = count;
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    // Parity is resolved from the head word at pop time so the frame carries one latched bit.
    always_comb begin
        n_bits   = {2'b00, data_len} + 4'd5;
        head_xor = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < n_bits) head_xor = head_xor ^ head[i];
        end
        case (parity_mode)
            2'b11:   par_bit_nx = ~head_xor;
            2'b10:   par_bit_nx = head_xor;
            2'b01:   par_bit_nx = 1'b1;
            default: par_bit_nx = 1'b0;
        endcase
    end

    assign tick     = (cnt == div_q);
    assign last_idx = {1'b0, len_q} + 3'd4;
    assign start_ok = en && !fifo_empty && !break_req;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (break_req)     state_nx = S_BREAK;
                else if (start_ok) state_nx = S_START;
            end
            S_START:  if (tick) state_nx = S_DATA;
            S_DATA:   if (tick && bit_idx == last_idx) state_nx = par_en_q ? S_PARITY : S_STOP1;
            S_PARITY: if (tick) state_nx = S_STOP1;
            S_STOP1:  if (tick) state_nx = stop2_q ? S_STOP2 : (start_ok ? S_START : S_IDLE);
            S_STOP2:  if (tick) state_nx = start_ok ? S_START : S_IDLE;
            S_BREAK:  if (!break_req) state_nx = S_GUARD;
            S_GUARD:  if (tick) state_nx = start_ok ? S_START : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        pop = (state_nx == S_START) && (state != S_START);
    end

    always_comb begin
        tx_nx = 1'b1;
        case (state)
            S_START, S_BREAK: tx_nx = 1'b0;
            S_DATA:           tx_nx = word_q[bit_idx];
            S_PARITY:         tx_nx = par_q;
            default:          tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            word_q   <= '0;
            len_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            div_q    <= '0;
            busy_q   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state  <= state_nx;
            busy_q <= (state != S_IDLE);
            tx     <= tx_nx;
            if (state_nx != state || tick || state == S_IDLE || state == S_BREAK)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
            if (pop) begin
                word_q   <= head;
                len_q    <= data_len;
                par_en_q <= parity_en;
                par_q    <= par_bit_nx;
                stop2_q  <= stop_bit_size;
                div_q    <= baud_div;
                bit_idx  <= '0;
            end else if (state == S_DATA && tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // The post-break guard period runs at the current divider.
            if (state == S_BREAK && state_nx == S_GUARD) div_q <= baud_div;
        end
    end

    // tx is registered, so busy_q keeps busy high until the last stop bit has left the pin.
    assign busy = (state != S_IDLE) || !fifo_empty || busy_q;

endmodule
